// File: rtl/bist_ctrl.sv
// BIST sequencer: clears the pattern generator and MISR, runs patterns, drains, then checks the signature.
// Optional macro BIST_SIG_READBACK_EN adds a sig_out port holding the signature captured in CHECK.
module bist_ctrl #(
    parameter int               WIDTH         = 8,
    parameter int               PATTERN_COUNT = 256,
    parameter int               WARMUP        = 17,
    parameter int               DRAIN         = 0,
    parameter logic [WIDTH-1:0] GOLDEN        = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] misr_sig,
    output logic             sub_rst,
    output logic             tpg_en,
    output logic             misr_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
`ifdef BIST_SIG_READBACK_EN
    output logic [WIDTH-1:0] sig_out,
`endif
    output logic [2:0]       dbg_state
);

    // Control handshake: start is a request sampled on any edge in IDLE (abort wins) or DONE;
    // it is ignored while busy. abort is honoured only while busy and is ignored in IDLE/DONE.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int RUN_LEN      = WARMUP + PATTERN_COUNT;
    localparam int CNT_W        = $clog2(RUN_LEN + DRAIN + 1);
    localparam int DRAIN_LAST_I = (DRAIN > 0) ? DRAIN - 1 : 0;

    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LAST_I);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sub_rst;
    logic             r_tpg_en;
    logic             r_misr_en;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_fail;

    state_t           w_state_nxt;
    logic             w_aborted;
    logic             w_match;
    logic             w_sub_rst;
    logic             w_tpg_en;
    logic             w_misr_en;
    logic             w_busy;
    logic             w_done;
    logic             w_pass;
    logic             w_fail;

    assign w_match = (misr_sig == GOLDEN);

    always_comb begin
        w_state_nxt = r_state;
        w_aborted   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && !abort) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: w_state_nxt = S_RUN;
            S_RUN: begin
                if (r_cnt == RUN_LAST) w_state_nxt = (DRAIN == 0) ? S_CHECK : S_DRAIN;
            end
            S_DRAIN: begin
                if (r_cnt == DRAIN_LAST) w_state_nxt = S_CHECK;
            end
            S_CHECK: w_state_nxt = S_DONE;
            S_DONE: begin
                if (start) w_state_nxt = S_CLEAR;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (r_busy && abort) begin
            w_state_nxt = S_IDLE;
            w_aborted   = 1'b1;
        end
    end

    // Outputs are decoded from the next state so every output is a flop.
    always_comb begin
        w_sub_rst = 1'b0;
        w_tpg_en  = 1'b0;
        w_misr_en = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_pass    = 1'b0;
        w_fail    = 1'b0;

        case (w_state_nxt)
            S_IDLE:  w_sub_rst = w_aborted;
            S_CLEAR: begin
                w_sub_rst = 1'b1;
                w_busy    = 1'b1;
            end
            S_RUN: begin
                w_tpg_en  = 1'b1;
                w_misr_en = 1'b1;
                w_busy    = 1'b1;
            end
            S_DRAIN: begin
                w_misr_en = 1'b1;
                w_busy    = 1'b1;
            end
            S_CHECK: w_busy = 1'b1;
            S_DONE: begin
                w_done = 1'b1;
                if (r_state == S_CHECK) begin
                    w_pass = w_match;
                    w_fail = !w_match;
                end else begin
                    w_pass = r_pass;
                    w_fail = r_fail;
                end
            end
            default: w_sub_rst = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sub_rst <= 1'b1;
            r_tpg_en  <= 1'b0;
            r_misr_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sub_rst <= w_sub_rst;
            r_tpg_en  <= w_tpg_en;
            r_misr_en <= w_misr_en;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_pass    <= w_pass;
            r_fail    <= w_fail;
            // Phase counter restarts on every state change and saturates instead of wrapping.
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef BIST_SIG_READBACK_EN
    logic [WIDTH-1:0] r_sig_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig_out <= '0;
        end else if (r_state == S_CHECK && w_state_nxt == S_DONE) begin
            r_sig_out <= misr_sig;
        end
    end

    assign sig_out = r_sig_out;
`endif

    assign sub_rst   = r_sub_rst;
    assign tpg_en    = r_tpg_en;
    assign misr_en   = r_misr_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bist_ctrl.sv
// Directed bench for bist_ctrl (WARMUP=17, PATTERN_COUNT=16, DRAIN=2, GOLDEN=8'h5A).
// Defining BIST_SIG_READBACK_EN also exercises sig_out.
module tb_bist_ctrl;

    localparam int W  = 8;
    localparam int NK = 41;

    logic         clk;
    logic         rst;
    logic         start;
    logic         abort;
    logic [W-1:0] misr_sig;
    logic         sub_rst;
    logic         tpg_en;
    logic         misr_en;
    logic         busy;
    logic         done;
    logic         pass;
    logic         fail;
    logic [2:0]   dbg_state;
`ifdef BIST_SIG_READBACK_EN
    logic [W-1:0] sig_out;
`endif

    int n_checks;
    int n_errors;

    // obs bit order: {sub_rst, tpg_en, misr_en, busy, done, pass, fail}
    logic [6:0]   obs[NK];
    logic [W-1:0] sig_obs[NK];
    logic [6:0]   exp_q[$];

    typedef struct {
        int         k;
        logic [6:0] exp;
    } vec_t;

    vec_t tab[9];

    bist_ctrl #(
        .WIDTH(8), .PATTERN_COUNT(16), .WARMUP(17), .DRAIN(2), .GOLDEN(8'h5A)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .misr_sig(misr_sig),
        .sub_rst(sub_rst), .tpg_en(tpg_en), .misr_en(misr_en), .busy(busy),
        .done(done), .pass(pass), .fail(fail),
`ifdef BIST_SIG_READBACK_EN
        .sig_out(sig_out),
`endif
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] cur_outs();
        return {sub_rst, tpg_en, misr_en, busy, done, pass, fail};
    endfunction

    // Start a run and sample outputs at the falling edge after each rising edge k (k=0 is the accepting edge).
    task automatic run_seq(input logic [W-1:0] chk, input int abort_k, input int rst_k, input int restart_k);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < NK; k++) begin
            @(negedge clk);
            obs[k] = cur_outs();
`ifdef BIST_SIG_READBACK_EN
            sig_obs[k] = sig_out;
`else
            sig_obs[k] = '0;
`endif
            start    = (k == restart_k);
            abort    = (k == abort_k);
            rst      = (k == rst_k);
            misr_sig = (k == 36) ? chk : ~chk;
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic check_table(input string tag, input logic good);
        logic [6:0] e;
        foreach (tab[i]) begin
            e = tab[i].exp;
            if (!good && e[2]) e[1:0] = 2'b01;
            exp_q.push_back(e);
        end
        foreach (tab[i]) begin
            e = exp_q.pop_front();
            check($sformatf("%s k=%0d", tag, tab[i].k), 32'(obs[tab[i].k]), 32'(e));
        end
    endtask

    task automatic check_counts(input string tag);
        int n_sub, n_tpg, n_misr, first_done;
        n_sub = 0; n_tpg = 0; n_misr = 0; first_done = -1;
        for (int k = 0; k < NK; k++) begin
            n_sub  += int'(obs[k][6]);
            n_tpg  += int'(obs[k][5]);
            n_misr += int'(obs[k][4]);
            if (obs[k][2] && first_done < 0) first_done = k;
        end
        check({tag, " sub_rst cycles"}, 32'(n_sub), 32'd1);
        check({tag, " tpg_en cycles"}, 32'(n_tpg), 32'd33);
        check({tag, " misr_en cycles"}, 32'(n_misr), 32'd35);
        check({tag, " done latency"}, 32'(first_done), 32'd37);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        tab[0] = '{0,  7'b1001000};
        tab[1] = '{1,  7'b0111000};
        tab[2] = '{10, 7'b0111000};
        tab[3] = '{33, 7'b0111000};
        tab[4] = '{34, 7'b0011000};
        tab[5] = '{35, 7'b0011000};
        tab[6] = '{36, 7'b0001000};
        tab[7] = '{37, 7'b0000110};
        tab[8] = '{40, 7'b0000110};

        rst = 1'b1; start = 1'b1; abort = 1'b0; misr_sig = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", 32'(cur_outs()), 32'(7'b1000000));
`ifdef BIST_SIG_READBACK_EN
        check("reset sig_out", 32'(sig_out), 32'h0);
`endif
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("after reset", 32'(cur_outs()), 32'(7'b0000000));

        // start together with abort in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        check("idle abort priority", 32'(cur_outs()), 32'(7'b0000000));
        start = 1'b0; abort = 1'b0;

        // passing run; abort during DONE must be ignored
        run_seq(8'h5A, 38, -1, -1);
        check_table("pass", 1'b1);
        check_counts("pass");
        check("abort in done", 32'(obs[39]), 32'(7'b0000110));

        // single-bit mismatch, started from DONE
        run_seq(8'h5B, -1, -1, -1);
        check_table("fail", 1'b0);
        check_counts("fail");

        // start reasserted mid-RUN is ignored
        run_seq(8'h5A, -1, -1, 10);
        check_table("restart", 1'b1);
        check_counts("restart");

        // abort on RUN cycle 10
        run_seq(8'h5A, 10, -1, -1);
        check("abort k10", 32'(obs[10]), 32'(7'b0111000));
        check("abort k11", 32'(obs[11]), 32'(7'b1000000));
        check("abort k12", 32'(obs[12]), 32'(7'b0000000));
        check("abort k40", 32'(obs[40]), 32'(7'b0000000));

        // rst during DRAIN
        run_seq(8'h5A, -1, 34, -1);
        check("rst k34", 32'(obs[34]), 32'(7'b0011000));
        check("rst k35", 32'(obs[35]), 32'(7'b1000000));
        check("rst k36", 32'(obs[36]), 32'(7'b0000000));
        check("rst k40", 32'(obs[40]), 32'(7'b0000000));

`ifdef BIST_SIG_READBACK_EN
        run_seq(8'h3C, -1, -1, -1);
        check("readback k37 outs", 32'(obs[37]), 32'(7'b0000101));
        check("readback k37 sig", 32'(sig_obs[37]), 32'h3C);
        check("readback k40 sig", 32'(sig_obs[40]), 32'h3C);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
